// File: rtl/registry_file_pkg.sv
// ---------------------------------------------------------------------------
// registry_file_pkg
//   Shared constants and types for the registry_file block.
//
//   DEFAULT_DATA_W : default width of one register / data port
//   DEFAULT_ADDR_W : default register-select width
//   NUM_REGS       : register count implied by DEFAULT_ADDR_W
//   data_t         : one data word at the default width
// ---------------------------------------------------------------------------
package registry_file_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int NUM_REGS       = 1 << DEFAULT_ADDR_W;

  typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage : registry_file_pkg

// File: rtl/registry_cell.sv
// ---------------------------------------------------------------------------
// registry_cell
//   One DATA_W-bit storage register with write enable and asynchronous
//   active-low clear. Used as the storage element of registry_file.
//
//   Ports:
//     clk   : clock, state updates on the rising edge
//     rst_n : asynchronous active-low reset, clears the register to 0
//     we_i  : write enable, loads d_i on the next rising edge
//     d_i   : data to store
//     q_o   : current register contents
// ---------------------------------------------------------------------------
module registry_cell #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // NOTE: combinational blocks assign every output on every path (here via
  // the ternary) so no latch is inferred.
  always_comb begin
    data_d = we_i ? d_i : data_q;
  end

  // NOTE: every storage cell is cleared by the async reset, because the
  // block must read back 0 from every address while rst_n is low; state is
  // updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : registry_cell

// File: rtl/registry_file.sv
// ---------------------------------------------------------------------------
// registry_file
//   2**ADDR_W x DATA_W register file: one synchronous write port and two
//   independent combinational read ports. Every register, including
//   register 0, is general purpose.
//
//   Parameters:
//     DATA_W : register / data width
//     ADDR_W : register-select width (2**ADDR_W registers)
//
//   Ports:
//     clk        : clock, writes happen on the rising edge
//     rst_n      : asynchronous active-low reset, clears all registers
//     read_reg1  : read port 1 select
//     read_reg2  : read port 2 select
//     read_data1 : contents of register read_reg1 (zero latency)
//     read_data2 : contents of register read_reg2 (zero latency)
//     write_reg  : write port select
//     write_data : value written on the edge
//     write_en   : write enable, active-high
//
//   Build option:
//     REGISTRY_FILE_BYPASS_EN : when defined, a read port selecting the
//       register currently being written (write_en=1, rst_n=1) returns
//       write_data combinationally. Undefined: reads always return stored
//       contents, so the new value appears only after the write edge.
// ---------------------------------------------------------------------------
module registry_file
  import registry_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en
);

  localparam int REG_CNT = 1 << ADDR_W;

  logic [DATA_W-1:0] cell_q [REG_CNT];
  logic [REG_CNT-1:0] cell_we;

  // One-hot write decode: only the selected cell sees its enable.
  for (genvar i = 0; i < REG_CNT; i++) begin : g_cell
    assign cell_we[i] = write_en && (write_reg == ADDR_W'(i));

    registry_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (cell_we[i]),
      .d_i   (write_data),
      .q_o   (cell_q[i])
    );
  end

`ifdef REGISTRY_FILE_BYPASS_EN
  // Write-through forwarding. Gated by rst_n so that reads stay 0 during
  // reset even if a write is being presented.
  logic fwd_active;
  assign fwd_active = write_en && rst_n;

  always_comb begin
    read_data1 = cell_q[read_reg1];
    read_data2 = cell_q[read_reg2];
    if (fwd_active && (read_reg1 == write_reg)) begin
      read_data1 = write_data;
    end
    if (fwd_active && (read_reg2 == write_reg)) begin
      read_data2 = write_data;
    end
  end
`else
  assign read_data1 = cell_q[read_reg1];
  assign read_data2 = cell_q[read_reg2];
`endif

endmodule : registry_file

// File: tb/tb_registry_file.sv
// ---------------------------------------------------------------------------
// tb_registry_file
//   Directed self-checking bench for registry_file at default parameters.
//   Build with or without REGISTRY_FILE_BYPASS_EN; expectations for the
//   read-during-write case follow the same macro.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_registry_file;
  import registry_file_pkg::*;

  localparam int AW = DEFAULT_ADDR_W;
  localparam int DW = DEFAULT_DATA_W;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] read_reg1;
  logic [AW-1:0] read_reg2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          write_en;

  int checks;
  int errors;

  registry_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .write_en   (write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] r, input data_t d);
    write_reg  = r;
    write_data = d;
    write_en   = 1'b1;
    tick();
    write_en   = 1'b0;
  endtask

  // Reset pulse with a write presented during it; the write must be lost.
  task automatic test_reset();
    rst_n      = 1'b0;
    write_en   = 1'b1;
    write_reg  = 3'd2;
    write_data = 8'h77;
    read_reg1  = 3'd0;
    read_reg2  = 3'd1;
    tick();
    tick();
    read_reg1 = 3'd2;
    #1;
    checks++;
    if (read_data1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_write_discard_in_reset: got %h expected 00", read_data1);
    end
    write_en = 1'b0;
    rst_n    = 1'b1;
    tick();
    read_reg1 = 3'd0;
    read_reg2 = 3'd1;
    #1;
    checks++;
    if (read_data1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd1_reg0: got %h expected 00", read_data1);
    end
    checks++;
    if (read_data2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd2_reg1: got %h expected 00", read_data2);
    end
    read_reg2 = 3'd2;
    #1;
    checks++;
    if (read_data2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_write_discarded_reg2: got %h expected 00", read_data2);
    end
  endtask

  task automatic test_write_reg0();
    do_write(3'd0, 8'hAA);
    read_reg1 = 3'd0;
    read_reg2 = 3'd1;
    #1;
    checks++;
    if (read_data1 !== 8'hAA) begin
      errors++;
      $display("FAIL wr0_rd1_reg0: got %h expected aa", read_data1);
    end
    checks++;
    if (read_data2 !== 8'h00) begin
      errors++;
      $display("FAIL wr0_rd2_reg1: got %h expected 00", read_data2);
    end
  endtask

  task automatic test_write_reg1_and_hold();
    do_write(3'd1, 8'h55);
    read_reg1 = 3'd0;
    read_reg2 = 3'd1;
    #1;
    checks++;
    if (read_data1 !== 8'hAA) begin
      errors++;
      $display("FAIL wr1_rd1_reg0: got %h expected aa", read_data1);
    end
    checks++;
    if (read_data2 !== 8'h55) begin
      errors++;
      $display("FAIL wr1_rd2_reg1: got %h expected 55", read_data2);
    end
    // write_en low: data on the bus must not land anywhere.
    write_en   = 1'b0;
    write_data = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      write_reg = AW'(k);
      tick();
    end
    checks++;
    if (read_data1 !== 8'hAA) begin
      errors++;
      $display("FAIL hold_rd1_reg0: got %h expected aa", read_data1);
    end
    checks++;
    if (read_data2 !== 8'h55) begin
      errors++;
      $display("FAIL hold_rd2_reg1: got %h expected 55", read_data2);
    end
    read_reg1 = 3'd2;
    read_reg2 = 3'd3;
    #1;
    checks++;
    if (read_data1 !== 8'h00 || read_data2 !== 8'h00) begin
      errors++;
      $display("FAIL hold_reg2_reg3: got %h/%h expected 00/00", read_data1, read_data2);
    end
  endtask

  task automatic test_sweep_and_async_reset();
    data_t exp1;
    data_t exp2;
    for (int i = 0; i < 8; i++) begin
      do_write(AW'(i), 8'h10 + 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      read_reg1 = AW'(i);
      read_reg2 = AW'(7 - i);
      exp1 = 8'h10 + 8'(i);
      exp2 = 8'h10 + 8'(7 - i);
      #1;
      checks++;
      if (read_data1 !== exp1) begin
        errors++;
        $display("FAIL sweep_rd1 addr %0d: got %h expected %h", i, read_data1, exp1);
      end
      checks++;
      if (read_data2 !== exp2) begin
        errors++;
        $display("FAIL sweep_rd2 addr %0d: got %h expected %h", 7 - i, read_data2, exp2);
      end
    end
    // Assert reset mid-sweep, well clear of the next edge, and check all
    // addresses before that edge arrives.
    tick();
    read_reg1 = 3'd0;
    read_reg2 = 3'd4;
    #1;
    checks++;
    if (read_data1 !== 8'h10 || read_data2 !== 8'h14) begin
      errors++;
      $display("FAIL sweep_pre_reset: got %h/%h expected 10/14", read_data1, read_data2);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_reg1 = AW'(i);
      read_reg2 = AW'(i + 4);
      #1;
      checks++;
      if (read_data1 !== 8'h00 || read_data2 !== 8'h00) begin
        errors++;
        $display("FAIL async_reset addr %0d/%0d: got %h/%h expected 00/00",
                 i, i + 4, read_data1, read_data2);
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_during_write();
    data_t exp_pre;
`ifdef REGISTRY_FILE_BYPASS_EN
    exp_pre = 8'h3C;
`else
    exp_pre = 8'h00;
`endif
    read_reg1  = 3'd3;
    read_reg2  = 3'd4;
    write_reg  = 3'd3;
    write_data = 8'h3C;
    write_en   = 1'b1;
    #1;
    checks++;
    if (read_data1 !== exp_pre) begin
      errors++;
      $display("FAIL rdw_before_edge: got %h expected %h", read_data1, exp_pre);
    end
    checks++;
    if (read_data2 !== 8'h00) begin
      errors++;
      $display("FAIL rdw_other_port: got %h expected 00", read_data2);
    end
    tick();
    write_en  = 1'b0;
    read_reg2 = 3'd3;
    #1;
    checks++;
    if (read_data1 !== 8'h3C || read_data2 !== 8'h3C) begin
      errors++;
      $display("FAIL rdw_after_edge: got %h/%h expected 3c/3c", read_data1, read_data2);
    end
    read_reg2 = 3'd4;
    #1;
    checks++;
    if (read_data2 !== 8'h00) begin
      errors++;
      $display("FAIL rdw_neighbour_untouched: got %h expected 00", read_data2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n      = 1'b0;
    read_reg1  = '0;
    read_reg2  = '0;
    write_reg  = '0;
    write_data = '0;
    write_en   = 1'b0;
    test_reset();
    test_write_reg0();
    test_write_reg1_and_hold();
    test_sweep_and_async_reset();
    test_read_during_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_registry_file

// File: doc/registry_file.md
REGISTRY_FILE -- requirements
Module: registry_file

Interface
REQ-001 Parameter DATA_W, default 8, width in bits of each register and data port.
REQ-002 Parameter ADDR_W, default 3, register address width; register count is 2**ADDR_W (8 at default).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 read_reg1  input  ADDR_W  read port 1 register select.
REQ-006 read_reg2  input  ADDR_W  read port 2 register select.
REQ-007 read_data1  output  DATA_W  contents of register read_reg1.
REQ-008 read_data2  output  DATA_W  contents of register read_reg2.
REQ-009 write_reg  input  ADDR_W  write port register select.
REQ-010 write_data  input  DATA_W  value to write.
REQ-011 write_en  input  1  write enable, active-high.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers of DATA_W bits each; all registers, including register 0, are general-purpose and writable.
REQ-013 On a rising clk edge with write_en=1, register write_reg SHALL take write_data; no other register changes.
REQ-014 With write_en=0 at a rising edge, no register SHALL change.
REQ-015 Read ports SHALL be combinational: read_data1/read_data2 follow read_reg1/read_reg2 and register contents with zero clock latency.
REQ-016 Both read ports SHALL be independent; equal read_reg1 and read_reg2 return the same value on both outputs.
REQ-017 A read of the register being written SHALL return the pre-edge value until the write edge and the new value immediately after it (unless REQ-022 applies).
REQ-018 Write data SHALL be stored unmodified at full DATA_W width; no sign or zero extension, no arithmetic.
REQ-019 Out-of-range addresses cannot occur (address space is exactly 2**ADDR_W); no error output exists.

Reset
REQ-020 While rst_n=0, all registers SHALL be forced to 0 asynchronously; both read outputs therefore read 0 for every address.
REQ-021 Reset SHALL take priority over a simultaneous write; a write with write_en=1 at an edge while rst_n=0 is discarded, and the first write takes effect on the first rising edge after rst_n returns to 1.

Configuration
REQ-022 Macro REGISTRY_FILE_BYPASS_EN: when defined, a read port whose select equals write_reg while write_en=1 and rst_n=1 SHALL output write_data combinationally (write-through forwarding), per port independently.
REQ-023 When REGISTRY_FILE_BYPASS_EN is undefined, no forwarding logic SHALL be present and REQ-017 applies unconditionally.

Structure
REQ-024 A package registry_file_pkg SHALL hold the default DATA_W/ADDR_W constants, the derived register count, and a data-word typedef.
REQ-025 The storage element SHALL be a sub-module registry_cell (one DATA_W register with async active-low reset and write enable), instantiated 2**ADDR_W times; address decode and read muxes live in registry_file.

Verification
REQ-026 Reset pulse then read_reg1=0, read_reg2=1 -> read_data1=0x00, read_data2=0x00.
REQ-027 write_en=1, write_reg=0, write_data=0xAA for one edge, then read 0 and 1 -> read_data1=0xAA, read_data2=0x00.
REQ-028 Then write 0x55 to register 1, read 0 and 1 -> read_data1=0xAA, read_data2=0x55; write_en=0 with write_data=0xFF for several edges -> values unchanged.
REQ-029 Write 0x10+i to each register i=0..7, sweep both ports over all addresses -> each returns 0x10+i; asserting rst_n=0 mid-sweep -> all reads 0x00 immediately, without waiting for a clock edge.
REQ-030 read_reg1=3, write_reg=3, write_data=0x3C, write_en=1 before the edge -> read_data1 shows the old value (0x00 after reset) without REGISTRY_FILE_BYPASS_EN, 0x3C with it; after the edge 0x3C in both builds.
